// File: rtl/add_share_pkg.sv
// Shared types for the time-shared adder scheduler: FSM state encoding and requester id width.
package add_share_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam int REQ_ID_W = 1;
endpackage

// File: rtl/add_share_rr_arb.sv
// Two-way round-robin grant: a lone valid wins outright, a tie goes to the requester
// that did not win last time.
module add_share_rr_arb (
    input  logic [1:0] valid_i,
    input  logic       rr_last_i,
    output logic [1:0] grant_o
);
    always_comb begin
        grant_o = 2'b00;
        unique case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = rr_last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end
endmodule

// File: rtl/add_share_sched.sv
// One WIDTH-bit adder shared by two valid/ready requesters, one transaction in flight.
// Build option ADD_SHARE_SCHED_STATS_EN adds saturating per-requester grant counters.
module add_share_sched
    import add_share_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output state_t           dbg_state
);
    // Handshake: a side transfers in a cycle where its valid and ready are both high at the
    // rising edge; ready may depend on valid, and result outputs hold while res_valid&~res_ready.
    state_t                state_q, state_d;
    logic                  rr_last_q, rr_last_d;
    logic [WIDTH-1:0]      sum_q, sum_d;
    logic                  carry_q, carry_d;
    logic [REQ_ID_W-1:0]   id_q, id_d;
    logic [1:0]            arb_grant;
    logic [1:0]            grant;

    add_share_rr_arb u_arb (
        .valid_i   ({req1_valid, req0_valid}),
        .rr_last_i (rr_last_q),
        .grant_o   (arb_grant)
    );

    // Grants only exist in IDLE and never while reset is asserted.
    assign grant      = (state_q == IDLE && rst_n) ? arb_grant : 2'b00;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        id_d      = id_q;
        unique case (state_q)
            IDLE: begin
                if (grant[1]) begin
                    {carry_d, sum_d} = {1'b0, req1_a} + {1'b0, req1_b};
                    id_d      = 1'b1;
                    rr_last_d = 1'b1;
                    state_d   = RESP;
                end else if (grant[0]) begin
                    {carry_d, sum_d} = {1'b0, req0_a} + {1'b0, req0_b};
                    id_d      = 1'b0;
                    rr_last_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            id_q      <= id_d;
        end
    end

    assign res_valid = (state_q == RESP);
    assign res_sum   = sum_q;
    assign res_carry = carry_q;
    assign res_id    = id_q;
    assign dbg_state = state_q;

`ifdef ADD_SHARE_SCHED_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (grant[0] && cnt0_q != CNT_MAX) cnt0_q <= cnt0_q + CNT_ONE;
            if (grant[1] && cnt1_q != CNT_MAX) cnt1_q <= cnt1_q + CNT_ONE;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif
endmodule

// File: tb/tb_add_share_sched.sv
// Directed bench for add_share_sched: handshake timing, round-robin order, overflow,
// back-pressure, reset mid-result and grant counters.
module tb_add_share_sched;
    import add_share_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             res_valid, res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_carry, res_id;
    logic [CNT_W-1:0] cnt0, cnt1;
    state_t           dbg_state;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] hold_sum;
    logic             hold_id;
    logic             exp_id;

    add_share_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_carry  (res_carry),
        .res_id     (res_id),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00;
        step(); step();
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_valid",  {31'd0, res_valid}, 32'd0);
        check("rst_sum",    {24'd0, res_sum}, 32'd0);
        check("rst_carry",  {31'd0, res_carry}, 32'd0);
        check("rst_id",     {31'd0, res_id}, 32'd0);
        check("rst_cnt",    {28'd0, cnt1, cnt0}, 32'd0);

        req0_valid = 1'b0;
        rst_n = 1'b1; res_ready = 1'b1;
        step();
        check("idle_noreq", {31'd0, res_valid}, 32'd0);

        // Single req0 accept: 0x12+0x34.
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
        #1;
        check("t1_ready0", {30'd0, req1_ready, req0_ready}, 32'b01);
        check("t1_noval",  {31'd0, res_valid}, 32'd0);
        step();
        req0_valid = 1'b0;
        check("t1_valid", {31'd0, res_valid}, 32'd1);
        check("t1_sum",   {23'd0, res_carry, res_sum}, 32'h046);
        check("t1_id",    {31'd0, res_id}, 32'd0);
        step();
        check("t1_idle",  {31'd0, res_valid}, 32'd0);

        // Overflow on req1, then on req0.
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01;
        #1;
        check("t3_ready1", {30'd0, req1_ready, req0_ready}, 32'b10);
        step();
        req1_valid = 1'b0;
        check("t3_ovf1",  {23'd0, res_carry, res_sum}, 32'h100);
        check("t3_id1",   {31'd0, res_id}, 32'd1);
        step();
        req0_valid = 1'b1; req0_a = 8'h80; req0_b = 8'h80;
        step();
        req0_valid = 1'b0;
        check("t3_ovf0",  {23'd0, res_carry, res_sum}, 32'h100);
        check("t3_id0",   {31'd0, res_id}, 32'd0);
        step();

        // Both continuously valid: last winner was req0, so req1 first, then alternate.
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h20;
        exp_id = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_grant", {30'd0, req1_ready, req0_ready}, exp_id ? 32'b10 : 32'b01);
            step();
            check("t2_valid", {31'd0, res_valid}, 32'd1);
            check("t2_id",    {31'd0, res_id}, {31'd0, exp_id});
            check("t2_sum",   {23'd0, res_carry, res_sum}, exp_id ? 32'h030 : 32'h003);
            check("t2_noacc", {30'd0, req1_ready, req0_ready}, 32'd0);
            step();
            check("t2_idle",  {31'd0, res_valid}, 32'd0);
            exp_id = ~exp_id;
        end

        // Back-pressure: req1 wins (req0 was last), result held for 5 cycles.
        res_ready = 1'b0;
        step();
        hold_sum = res_sum; hold_id = res_id;
        check("t4_id", {31'd0, res_id}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_valid", {31'd0, res_valid}, 32'd1);
            check("t4_sum",   {24'd0, res_sum}, {24'd0, hold_sum});
            check("t4_hid",   {31'd0, res_id}, {31'd0, hold_id});
            check("t4_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            check("t4_state", {31'd0, dbg_state}, {31'd0, RESP});
        end
        res_ready = 1'b1;
        step();
        check("t4_release", {31'd0, res_valid}, 32'd0);
        check("t4_other",   {30'd0, req1_ready, req0_ready}, 32'b01);
        step();
        check("t4_id0", {31'd0, res_id}, 32'd0);

        // Reset while holding a result; first tie afterwards goes to req0.
        rst_n = 1'b0;
        step();
        check("t5_valid", {31'd0, res_valid}, 32'd0);
        check("t5_sum",   {24'd0, res_sum}, 32'd0);
        check("t5_id",    {31'd0, res_id}, 32'd0);
        check("t5_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check("t5_cnt",   {28'd0, cnt1, cnt0}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("t5_tie", {30'd0, req1_ready, req0_ready}, 32'b01);

        // Five req0 accepts: counter saturates at 3 when stats are built.
        req1_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            step();
        end
`ifdef ADD_SHARE_SCHED_STATS_EN
        check("t6_cnt0", {30'd0, cnt0}, 32'd3);
`else
        check("t6_cnt0", {30'd0, cnt0}, 32'd0);
`endif
        check("t6_cnt1", {30'd0, cnt1}, 32'd0);
        req0_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
